seven_seg_scanner: RTL and testbench

- Downstream display stage for the digital clock's six BCD digit outputs (sec/min/hour ones/tens).
- Time-multiplexes the six digits onto a 6-digit 7-segment display with a shared segment bus and per-digit enables.
- Freezes the digits once per scan frame to prevent tearing.
- Inserts a blanking gap between digits against ghosting, blanks a leading hour zero, and drives colon dots.

---
 rtl/clock_display_pkg.sv | 31 +++
 rtl/bcd_to_seg.sv | 26 ++
 rtl/seven_seg_scanner.sv | 123 ++++++++++++
 tb/tb_seven_seg_scanner.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_display_pkg.sv
// Shared constants for the clock display path: segment codes, digit slots, scan states.
package clock_display_pkg;

  // Active-high segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  localparam logic [2:0] IDX_SEC_ONES  = 3'd0;
  localparam logic [2:0] IDX_SEC_TENS  = 3'd1;
  localparam logic [2:0] IDX_MIN_ONES  = 3'd2;
  localparam logic [2:0] IDX_MIN_TENS  = 3'd3;
  localparam logic [2:0] IDX_HOUR_ONES = 3'd4;
  localparam logic [2:0] IDX_HOUR_TENS = 3'd5;

  localparam int unsigned NUM_DIGITS = 6;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-high 7-segment decoder; codes above 9 show a dash.
module bcd_to_seg
  import clock_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Six-digit multiplexed 7-segment scanner with per-frame snapshot, inter-digit
// blanking, leading hour-zero suppression and colon dots.
module seven_seg_scanner
  import clock_display_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ   = 1_200_000,
  parameter int unsigned DIGIT_HOLD   = 1000,
  parameter int unsigned BLANK_CYCLES = 20,
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter bit          LZ_BLANK     = 1'b1
)
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       colon_on,
  input  logic [3:0] sec_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] min_tens,
  input  logic [3:0] hour_ones,
  input  logic [3:0] hour_tens,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int unsigned CNT_MAX = (DIGIT_HOLD > BLANK_CYCLES) ? DIGIT_HOLD : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(DIGIT_HOLD - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SEG_LOAD   = CNT_W'(1);

  localparam logic [5:0] AN_OFF  = {6{ACTIVE_LOW}};
  localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic       DP_OFF  = ACTIVE_LOW;

  if (DIGIT_HOLD < 1 || BLANK_CYCLES < 2 || CLOCK_FREQ == 0) begin : g_param_check
    $error("seven_seg_scanner: DIGIT_HOLD >= 1, BLANK_CYCLES >= 2, CLOCK_FREQ > 0 required");
  end

  scan_state_t           state;
  logic [CNT_W-1:0]      cnt;
  logic [2:0]            idx;
  logic [5:0][3:0]       snap;
  logic                  colon_snap;

  logic [3:0] cur_digit;
  logic [6:0] dec_seg;
  logic [6:0] seg_next;
  logic       dp_next;

  always_comb begin
    cur_digit = '0;
    if (idx <= IDX_HOUR_TENS) cur_digit = snap[idx];
  end

  bcd_to_seg u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  always_comb begin
    seg_next = dec_seg;
    if (LZ_BLANK && idx == IDX_HOUR_TENS && cur_digit == 4'd0) seg_next = '0;
    dp_next = colon_snap && (idx == IDX_MIN_ONES || idx == IDX_HOUR_ONES);
  end

  // Outputs are held at their final polarity; only this register stage sees ACTIVE_LOW.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      snap       <= '0;
      colon_snap <= 1'b0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
    end else begin
      if (state == BLANK && idx == IDX_SEC_ONES && cnt == '0) begin
        snap       <= {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones};
        colon_snap <= colon_on;
      end
      if (state == BLANK && cnt == SEG_LOAD) begin
        seg <= seg_next ^ SEG_OFF;
        dp  <= dp_next ^ DP_OFF;
      end
      case (state)
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state <= DRIVE;
            cnt   <= '0;
            an    <= ((6'd1 << idx) & {6{enable}}) ^ AN_OFF;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DRIVE: begin
          if (cnt == HOLD_LAST) begin
            state <= BLANK;
            cnt   <= '0;
            an    <= AN_OFF;
            idx   <= (idx == IDX_HOUR_TENS) ? '0 : idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
            // Enable is only sampled on slot entry, so re-asserting it mid-slot keeps the digit dark.
            if (!enable) an <= AN_OFF;
          end
        end
        default: begin
          state <= BLANK;
          cnt   <= '0;
          an    <= AN_OFF;
        end
      endcase
    end
  end

  a_an_onehot0: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(an ^ AN_OFF));

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: active-high main instance plus an active-low instance.
module tb_seven_seg_scanner;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rst2_n = 1'b0;
  logic       enable = 1'b1;
  logic       colon_on = 1'b0;
  logic [3:0] sec_ones = '0, sec_tens = '0, min_ones = '0, min_tens = '0;
  logic [3:0] hour_ones = '0, hour_tens = '0;
  logic [6:0] seg, seg2;
  logic       dp, dp2;
  logic [5:0] an, an2;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .CLOCK_FREQ(1_200_000), .DIGIT_HOLD(4), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b0), .LZ_BLANK(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .colon_on(colon_on),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .hour_ones(hour_ones), .hour_tens(hour_tens), .seg(seg), .dp(dp), .an(an)
  );

  seven_seg_scanner #(
    .CLOCK_FREQ(1_200_000), .DIGIT_HOLD(4), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)
  ) dut_al (
    .clk(clk), .reset_n(rst2_n), .enable(enable), .colon_on(colon_on),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .hour_ones(hour_ones), .hour_tens(hour_tens), .seg(seg2), .dp(dp2), .an(an2)
  );

  typedef struct {
    logic [5:0] an_first;
    logic [5:0] an_last;
    logic [6:0] seg;
    logic       dp;
    int         slot;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc;
  int   mon_o;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;  4'd3: return 7'h4F;
      4'd4: return 7'h66;  4'd5: return 7'h6D;  4'd6: return 7'h7D;  4'd7: return 7'h07;
      4'd8: return 7'h7F;  4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Expected slots for the frame whose snapshot is taken from the inputs as they stand now.
  task automatic push_frame(input int dis_slot, input int en_slot);
    logic [3:0] d [6];
    d = '{sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens};
    for (int s = 0; s < 6; s++) begin
      exp_t e;
      bit   en_entry;
      en_entry   = !(dis_slot >= 0 && s > dis_slot && (en_slot < 0 || s <= en_slot));
      e.an_first = en_entry ? 6'(1 << s) : 6'd0;
      e.an_last  = (en_entry && s != dis_slot) ? e.an_first : 6'd0;
      e.seg      = (s == 5 && d[s] == 4'd0) ? 7'h00 : ref_seg(d[s]);
      e.dp       = colon_on && (s == 2 || s == 4);
      e.slot     = s;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int n);
    int g;
    g = 0;
    while (cyc < n) begin
      @(negedge clk);
      g++;
      if (g > 5000) begin
        checks++;
        failures++;
        $display("FAIL wait_timeout target_cyc=%0d now=%0d", n, cyc);
        return;
      end
    end
  endtask

  // Slot s of the run drives after edges 6s+2..6s+5 and blanks after 6s+6, 6s+7.
  always @(negedge clk) begin
    if (reset_n && cyc >= 2) begin
      mon_o = (cyc - 2) % 6;
      if (mon_o == 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          have_cur = 1'b0;
          $display("FAIL sb_underflow cyc=%0d", cyc);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          if ({an, seg, dp} !== {cur.an_first, cur.seg, cur.dp}) begin
            failures++;
            $display("FAIL sb_slot%0d_start cyc=%0d got an=%b seg=%h dp=%b exp an=%b seg=%h dp=%b",
                     cur.slot, cyc, an, seg, dp, cur.an_first, cur.seg, cur.dp);
          end
        end
      end else if (mon_o == 3 && have_cur) begin
        checks++;
        if ({an, seg, dp} !== {cur.an_last, cur.seg, cur.dp}) begin
          failures++;
          $display("FAIL sb_slot%0d_end cyc=%0d got an=%b seg=%h dp=%b exp an=%b seg=%h dp=%b",
                   cur.slot, cyc, an, seg, dp, cur.an_last, cur.seg, cur.dp);
        end
      end else if (mon_o >= 4) begin
        checks++;
        if (an !== 6'd0) begin
          failures++;
          $display("FAIL sb_blank cyc=%0d got an=%b exp an=%b", cyc, an, 6'd0);
        end
      end
    end
  end

  task automatic test_reset;
    {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones} = {4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd8};
    colon_on = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({an, seg, dp} !== 14'd0) begin
      failures++;
      $display("FAIL reset_al0 got an=%b seg=%h dp=%b exp an=000000 seg=00 dp=0", an, seg, dp);
    end
    checks++;
    if ({an2, seg2, dp2} !== {6'h3F, 7'h7F, 1'b1}) begin
      failures++;
      $display("FAIL reset_al1 got an=%b seg=%h dp=%b exp an=111111 seg=7f dp=1", an2, seg2, dp2);
    end
    push_frame(-1, -1);
    reset_n = 1'b1;
    rst2_n  = 1'b1;
    wait_cyc(1);
    checks++;
    if (an !== 6'd0) begin
      failures++;
      $display("FAIL first_blank got an=%b exp an=%b", an, 6'd0);
    end
    wait_cyc(2);
    checks++;
    if (an !== 6'b000001) begin
      failures++;
      $display("FAIL first_an_latency got an=%b exp an=%b", an, 6'b000001);
    end
    wait_cyc(6);
    checks++;
    if (an !== 6'd0) begin
      failures++;
      $display("FAIL hold_4_cycles got an=%b exp an=%b", an, 6'd0);
    end
    wait_cyc(8);
    checks++;
    if (an !== 6'b000010) begin
      failures++;
      $display("FAIL second_slot got an=%b exp an=%b", an, 6'b000010);
    end
  endtask

  task automatic test_decode;
    logic [6:0] exp_seg [6];
    exp_seg = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
    wait_cyc(36);
    {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    colon_on = 1'b1;
    push_frame(-1, -1);
    wait_cyc(38);
    checks++;
    if (an !== 6'b000001) begin
      failures++;
      $display("FAIL frame_period got an=%b exp an=%b", an, 6'b000001);
    end
    for (int s = 0; s < 6; s++) begin
      wait_cyc(36 + 2 + 6 * s + 1);
      checks++;
      if (seg !== exp_seg[s] || dp !== (s == 2 || s == 4)) begin
        failures++;
        $display("FAIL decode_slot%0d got seg=%h dp=%b exp seg=%h dp=%b",
                 s, seg, dp, exp_seg[s], (s == 2 || s == 4));
      end
    end
  endtask

  task automatic test_tear;
    wait_cyc(72);
    push_frame(-1, -1);
    wait_cyc(72 + 10);
    sec_ones = 4'd7;
    min_tens = 4'd9;
    wait_cyc(72 + 20);
    checks++;
    if (seg !== 7'h4F) begin
      failures++;
      $display("FAIL tear_same_frame got seg=%h exp seg=%h", seg, 7'h4F);
    end
    wait_cyc(108);
    push_frame(-1, -1);
    wait_cyc(110);
    checks++;
    if (seg !== 7'h07) begin
      failures++;
      $display("FAIL tear_next_frame got seg=%h exp seg=%h", seg, 7'h07);
    end
    wait_cyc(108 + 20);
    checks++;
    if (seg !== 7'h6F) begin
      failures++;
      $display("FAIL tear_next_frame_tens got seg=%h exp seg=%h", seg, 7'h6F);
    end
  endtask

  task automatic test_leading_zero;
    wait_cyc(144);
    hour_tens = 4'd0;
    hour_ones = 4'd5;
    sec_ones  = 4'hC;
    push_frame(-1, -1);
    wait_cyc(146);
    checks++;
    if (seg !== 7'h40) begin
      failures++;
      $display("FAIL invalid_dash got seg=%h exp seg=%h", seg, 7'h40);
    end
    wait_cyc(176);
    checks++;
    if (an !== 6'b100000 || seg !== 7'h00) begin
      failures++;
      $display("FAIL lz_blank got an=%b seg=%h exp an=%b seg=%h", an, seg, 6'b100000, 7'h00);
    end
  endtask

  task automatic test_enable;
    wait_cyc(180);
    push_frame(3, 5);
    wait_cyc(180 + 20);
    enable = 1'b0;
    wait_cyc(180 + 21);
    checks++;
    if (an !== 6'd0) begin
      failures++;
      $display("FAIL enable_drop got an=%b exp an=%b", an, 6'd0);
    end
    wait_cyc(180 + 32);
    enable = 1'b1;
    wait_cyc(180 + 34);
    checks++;
    if (an !== 6'd0) begin
      failures++;
      $display("FAIL enable_midslot got an=%b exp an=%b", an, 6'd0);
    end
    wait_cyc(216);
    push_frame(-1, -1);
    wait_cyc(218);
    checks++;
    if (an !== 6'b000001) begin
      failures++;
      $display("FAIL enable_resume got an=%b exp an=%b", an, 6'b000001);
    end
  endtask

  task automatic test_polarity;
    wait_cyc(252);
    {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones} = {6{4'd8}};
    colon_on = 1'b0;
    push_frame(-1, -1);
    wait_cyc(252 + 14);
    checks++;
    if ({an2, seg2, dp2} !== {6'h3B, 7'h00, 1'b1}) begin
      failures++;
      $display("FAIL al_drive got an=%b seg=%h dp=%b exp an=%b seg=%h dp=%b",
               an2, seg2, dp2, 6'h3B, 7'h00, 1'b1);
    end
    wait_cyc(252 + 18);
    checks++;
    if (an2 !== 6'h3F) begin
      failures++;
      $display("FAIL al_idle got an=%b exp an=%b", an2, 6'h3F);
    end
    wait_cyc(252 + 20);
    checks++;
    if (an2 !== 6'h37) begin
      failures++;
      $display("FAIL al_drive_slot3 got an=%b exp an=%b", an2, 6'h37);
    end
    #1 rst2_n = 1'b0;
    #1;
    checks++;
    if ({an2, seg2, dp2} !== {6'h3F, 7'h7F, 1'b1}) begin
      failures++;
      $display("FAIL al_async_reset got an=%b seg=%h dp=%b exp an=%b seg=%h dp=%b",
               an2, seg2, dp2, 6'h3F, 7'h7F, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_tear();
    test_leading_zero();
    test_enable();
    test_polarity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
